// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU opcode encoding and multiplier FSM states.
package pipe_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;
    localparam logic [3:0] ALU_MUL = 4'd11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mul_state_e;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, write-back forwarding inputs and the registered EX/MEM bundle.
interface execute_stage_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite;
    logic [3:0]       DX_ALUctr;
    logic             DX_ALUSrc;
    logic [4:0]       DX_RS, DX_RT, DX_RD;
    logic [WIDTH-1:0] DX_A, DX_B, DX_IMM;

    logic             MW_RegWrite;
    logic [4:0]       MW_RD;
    logic [WIDTH-1:0] WB_data;

    logic             ex_stall;
    logic             XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
    logic [WIDTH-1:0] ALUout, XM_MD;
    logic [4:0]       XM_RD;

    modport master (
        output DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite, DX_ALUctr, DX_ALUSrc,
               DX_RS, DX_RT, DX_RD, DX_A, DX_B, DX_IMM, MW_RegWrite, MW_RD, WB_data,
        input  ex_stall, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, ALUout, XM_MD,
               XM_RD
    );

    modport slave (
        input  DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite, DX_ALUctr, DX_ALUSrc,
               DX_RS, DX_RT, DX_RD, DX_A, DX_B, DX_IMM, MW_RegWrite, MW_RD, WB_data,
        output ex_stall, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, ALUout, XM_MD,
               XM_RD
    );

endinterface

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits kept.
module iter_mul
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(MUL_CYCLES - 1);

    mul_state_e       state_q;
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
    logic [CntW-1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_q  <= a;
                        mplier_q <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) state_q <= StDone;
                end
                // Product is consumed this cycle; never restart on the same instruction.
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy    = (state_q == StBusy);
    assign done    = (state_q == StDone);
    assign product = acc_q;

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: operand forwarding, ALU, iterative multiply with stall, EX/MEM register.
module execute_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave bus
);

    logic [WIDTH-1:0] fwd_a, fwd_b, op_b, alu_res, mul_product;
    logic             mul_busy, mul_done, mul_start, stall;
    logic [4:0]       shamt;

    // XM result is newer than write-back, so it wins.
    always_comb begin
        fwd_a = bus.DX_A;
        if (bus.DX_RS != '0 && bus.XM_RegWrite && bus.XM_RD == bus.DX_RS) begin
            fwd_a = bus.ALUout;
        end else if (bus.DX_RS != '0 && bus.MW_RegWrite && bus.MW_RD == bus.DX_RS) begin
            fwd_a = bus.WB_data;
        end
        fwd_b = bus.DX_B;
        if (bus.DX_RT != '0 && bus.XM_RegWrite && bus.XM_RD == bus.DX_RT) begin
            fwd_b = bus.ALUout;
        end else if (bus.DX_RT != '0 && bus.MW_RegWrite && bus.MW_RD == bus.DX_RT) begin
            fwd_b = bus.WB_data;
        end
    end

    assign op_b  = bus.DX_ALUSrc ? bus.DX_IMM : fwd_b;
    assign shamt = op_b[4:0];

    // A MUL sitting in DX stalls until the multiplier reports done.
    assign mul_start    = (bus.DX_ALUctr == ALU_MUL) && !mul_done;
    assign stall        = rst && (mul_busy || mul_start);
    assign bus.ex_stall = stall;

    iter_mul #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_iter_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (fwd_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_res = '0;
        case (bus.DX_ALUctr)
            ALU_ADD: alu_res = fwd_a + op_b;
            ALU_SUB: alu_res = fwd_a - op_b;
            ALU_AND: alu_res = fwd_a & op_b;
            ALU_OR:  alu_res = fwd_a | op_b;
            ALU_XOR: alu_res = fwd_a ^ op_b;
            ALU_NOR: alu_res = ~(fwd_a | op_b);
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            ALU_SLL: alu_res = fwd_a << shamt;
            ALU_SRL: alu_res = fwd_a >> shamt;
            ALU_SRA: alu_res = $signed(fwd_a) >>> shamt;
            ALU_LUI: alu_res = {op_b[15:0], {(WIDTH-16){1'b0}}};
            ALU_MUL: alu_res = mul_product;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.XM_MemtoReg <= 1'b0;
            bus.XM_RegWrite <= 1'b0;
            bus.XM_MemRead  <= 1'b0;
            bus.XM_MemWrite <= 1'b0;
            bus.XM_RD       <= '0;
            bus.ALUout      <= '0;
            bus.XM_MD       <= '0;
        end else if (stall) begin
            bus.XM_MemtoReg <= 1'b0;
            bus.XM_RegWrite <= 1'b0;
            bus.XM_MemRead  <= 1'b0;
            bus.XM_MemWrite <= 1'b0;
            bus.XM_RD       <= '0;
        end else begin
            bus.XM_MemtoReg <= bus.DX_MemtoReg;
            bus.XM_RegWrite <= bus.DX_RegWrite;
            bus.XM_MemRead  <= bus.DX_MemRead;
            bus.XM_MemWrite <= bus.DX_MemWrite;
            bus.XM_RD       <= bus.DX_RD;
            bus.ALUout      <= alu_res;
            bus.XM_MD       <= fwd_b;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: driver pushes model results, monitor pops on commit.
module tb_execute_stage;
    import pipe_pkg::*;

    localparam int W  = 32;
    localparam int MC = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    execute_stage_if #(.WIDTH(W)) bus ();

    execute_stage #(
        .WIDTH      (W),
        .MUL_CYCLES (MC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0]  ctrl;  // {MemtoReg, RegWrite, MemRead, MemWrite}
        logic [3:0]  op;
        logic        alusrc;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, imm;
        logic        mw_rw;
        logic [4:0]  mw_rd;
        logic [31:0] wb;
    } instr_t;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] md;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    bit          tb_done = 1'b0;
    logic        m_rw = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_alu = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] dx,
                                        input logic mw_rw, input logic [4:0] mw_rd,
                                        input logic [31:0] wb);
        if (r != 0 && m_rw && m_rd == r) return m_alu;
        if (r != 0 && mw_rw && mw_rd == r) return wb;
        return dx;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_NOR: return ~(a | b);
            ALU_SLT: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            ALU_SLL: return a << sh;
            ALU_SRL: return a >> sh;
            ALU_SRA: return 32'(int'(a) >>> sh);
            ALU_LUI: return b * 32'h0001_0000;
            ALU_MUL: return 32'(64'(a) * 64'(b));
            default: return 32'd0;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        r.ctrl   = 4'($urandom);
        r.op     = 4'($urandom_range(0, 15));
        r.alusrc = 1'($urandom);
        r.rs     = 5'($urandom_range(0, 7));
        r.rt     = 5'($urandom_range(0, 7));
        r.rd     = 5'($urandom_range(0, 7));
        r.a      = $urandom;
        r.b      = $urandom;
        r.imm    = $urandom;
        r.mw_rw  = 1'($urandom);
        r.mw_rd  = 5'($urandom_range(0, 7));
        r.wb     = $urandom;
        return r;
    endfunction

    task automatic drive(input instr_t i);
        {bus.DX_MemtoReg, bus.DX_RegWrite, bus.DX_MemRead, bus.DX_MemWrite} = i.ctrl;
        bus.DX_ALUctr   = i.op;
        bus.DX_ALUSrc   = i.alusrc;
        bus.DX_RS       = i.rs;
        bus.DX_RT       = i.rt;
        bus.DX_RD       = i.rd;
        bus.DX_A        = i.a;
        bus.DX_B        = i.b;
        bus.DX_IMM      = i.imm;
        bus.MW_RegWrite = i.mw_rw;
        bus.MW_RD       = i.mw_rd;
        bus.WB_data     = i.wb;
    endtask

    task automatic do_reset(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            rst = 1'b0;
            drive(rand_instr());
        end
        m_rw  = 1'b0;
        m_rd  = '0;
        m_alu = '0;
    endtask

    // Drives one instruction until it commits; abort_at > 0 resets after that many stall cycles.
    task automatic issue(input instr_t i, input int abort_at, input string tag);
        logic [31:0] a, b, ob, res, md;
        int n;
        @(negedge clk);
        rst = 1'b1;
        drive(i);
        a   = fwd(i.rs, i.a, i.mw_rw, i.mw_rd, i.wb);
        b   = fwd(i.rt, i.b, i.mw_rw, i.mw_rd, i.wb);
        ob  = i.alusrc ? i.imm : b;
        res = ref_alu(i.op, a, ob);
        md  = b;
        #1;
        check({tag, " stall"}, 32'(bus.ex_stall), 32'(i.op == ALU_MUL));
        if (i.op == ALU_MUL) begin
            n = 0;
            while (bus.ex_stall === 1'b1 && n < 100) begin
                n++;
                if (n == abort_at) begin
                    do_reset(2);
                    return;
                end
                @(negedge clk);
                bus.WB_data = $urandom;
                i.wb = bus.WB_data;
                #1;
            end
            check({tag, " stall cycles"}, 32'(n), 32'(MC + 1));
            m_rw = 1'b0;
            m_rd = '0;
            md   = fwd(i.rt, i.b, i.mw_rw, i.mw_rd, i.wb);
        end
        sb.push_back('{ctrl: i.ctrl, rd: i.rd, alu: res, md: md});
        m_rw  = i.ctrl[2];
        m_rd  = i.rd;
        m_alu = res;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] held;
        logic        pre_rst, pre_stall;
        held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (tb_done) break;
            pre_rst   = rst;
            pre_stall = bus.ex_stall;
            if (!pre_rst) check("stall in reset", 32'(bus.ex_stall), 32'd0);
            @(posedge clk);
            #1;
            if (!pre_rst) begin
                check("reset ctrl", 32'({bus.XM_MemtoReg, bus.XM_RegWrite, bus.XM_MemRead,
                                         bus.XM_MemWrite}), 32'd0);
                check("reset rd", 32'(bus.XM_RD), 32'd0);
                check("reset aluout", bus.ALUout, 32'd0);
                check("reset md", bus.XM_MD, 32'd0);
                held = '0;
            end else if (pre_stall) begin
                check("bubble ctrl", 32'({bus.XM_MemtoReg, bus.XM_RegWrite, bus.XM_MemRead,
                                          bus.XM_MemWrite}), 32'd0);
                check("bubble rd", 32'(bus.XM_RD), 32'd0);
                check("bubble aluout held", bus.ALUout, held);
            end else if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL commit with empty scoreboard: got aluout %h, want none at %0t",
                         bus.ALUout, $time);
            end else begin
                e = sb.pop_front();
                check("xm ctrl", 32'({bus.XM_MemtoReg, bus.XM_RegWrite, bus.XM_MemRead,
                                      bus.XM_MemWrite}), 32'(e.ctrl));
                check("xm rd", 32'(bus.XM_RD), 32'(e.rd));
                check("aluout", bus.ALUout, e.alu);
                check("xm md", bus.XM_MD, e.md);
                held = e.alu;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, want finish by %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : driver
        instr_t t;
        do_reset(2);

        t = '0; t.ctrl = 4'b0100; t.op = ALU_ADD; t.a = 5; t.b = 7;
        t.rs = 1; t.rt = 2; t.rd = 3;
        issue(t, 0, "add");

        t = '0; t.ctrl = 4'b0100; t.op = ALU_ADD; t.alusrc = 1; t.imm = 100; t.rd = 4;
        issue(t, 0, "seed xm");
        t = '0; t.ctrl = 4'b0100; t.op = ALU_ADD; t.alusrc = 1; t.imm = 1; t.a = 1;
        t.rs = 4; t.rd = 5; t.mw_rw = 1; t.mw_rd = 4; t.wb = 200;
        issue(t, 0, "fwd prio");
        t.rs = 0;
        issue(t, 0, "fwd rs0");

        t = '0; t.ctrl = 4'b0001; t.op = ALU_ADD; t.alusrc = 1; t.imm = 8; t.a = 32'h10;
        t.rs = 1; t.rt = 9; t.mw_rw = 1; t.mw_rd = 9; t.wb = 32'hDEAD;
        issue(t, 0, "store");

        t = '0; t.ctrl = 4'b0100; t.op = ALU_MUL; t.a = 32'hFFFF_FFFF; t.b = 3;
        t.rs = 1; t.rt = 2; t.rd = 6;
        issue(t, 0, "mul");

        t.a = 123; t.b = 456;
        issue(t, 10, "mul abort");
        t.a = 6; t.b = 7; t.rd = 7;
        issue(t, 0, "mul after abort");
        issue(t, 0, "mul back2back");

        repeat (250) issue(rand_instr(), 0, "rand");

        @(posedge clk);
        #3;
        tb_done = 1'b1;
        @(negedge clk);
        #3;
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
